// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, fixed latency.
// Optional macro DIV_ZERO_DETECT_EN short-circuits divide-by-zero straight to DONE.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   rem;        // partial remainder, one guard bit
    logic [WIDTH-1:0] dq;         // dividend shifts out the top, quotient shifts in the bottom
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             dz_flag;
    logic             zero_div;
    logic             last_step;
    logic [WIDTH+1:0] ext;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    assign last_step = (cnt == CW'(WIDTH - 1));

    // One restoring step: the extra top bit of trial is the borrow/sign.
    assign ext       = {rem, dq[WIDTH-1]};
    assign trial     = ext - {2'b00, dvsr};
    assign trial_neg = trial[WIDTH+1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment before the case keeps this purely
    // combinational; leaving a path unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = zero_div ? DONE : CALC;
            CALC: if (last_step) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem         <= '0;
            dq          <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            dz_flag     <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvsr    <= divisor;
                        cnt     <= '0;
                        dz_flag <= zero_div;
                        // A detected zero divisor preloads the final answer
                        // so DONE publishes it through the same path.
                        if (zero_div) begin
                            dq  <= '1;
                            rem <= {1'b0, dividend};
                        end else begin
                            dq  <= dividend;
                            rem <= '0;
                        end
                    end
                end
                CALC: begin
                    rem <= trial_neg ? ext[WIDTH:0] : trial[WIDTH:0];
                    dq  <= {dq[WIDTH-2:0], ~trial_neg};
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    quotient    <= dq;
                    remainder   <= rem[WIDTH-1:0];
                    div_by_zero <= dz_flag;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): table vectors, random
// operands against an arithmetic reference, and hand-written multi-cycle corner cases.
module tb_seq_restoring_divider;

    localparam int W = 8;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Reference: plain unsigned arithmetic; x/0 defined as all-ones remainder x.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat, output int busy_cycles);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = W'(int'(a) / int'(b));
            r = W'(int'(a) % int'(b));
        end
        dz          = DZ_EN && (b == 0);
        lat         = dz ? 1 : W + 1;
        busy_cycles = dz ? 0 : W;
    endtask

    // Launch one operation and observe it at negedges; k counts edges after the sampling edge.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q_out, output logic [W-1:0] r_out);
        logic [W-1:0] eq, er;
        logic         edz;
        int           elat, ebusy;
        int           busy_cnt, done_cnt, first_done;
        model(a, b, eq, er, edz, elat, ebusy);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start      = 1'b0;
        busy_cnt   = 0;
        done_cnt   = 0;
        first_done = -1;
        for (int k = 0; k <= W + 5; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            @(negedge clk);
        end
        check({name, "_latency"}, first_done, elat);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_busy_cycles"}, busy_cnt, ebusy);
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        check({name, "_div_by_zero"}, div_by_zero, edz);
        q_out = quotient;
        r_out = remainder;
    endtask

    initial begin
        vec_t         tbl[8];
        logic [W-1:0] q, r;
        int           done_k[$];
        logic [W-1:0] done_q[$];
        logic [W-1:0] done_r[$];
        int           extra_done;

        tbl[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2};
        tbl[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
        tbl[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5};
        tbl[3] = '{a: 8'd200, b: 8'd0,   q: 8'd255, r: 8'd200};
        tbl[4] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0};
        tbl[5] = '{a: 8'd8,   b: 8'd8,   q: 8'd1,   r: 8'd0};
        tbl[6] = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1};
        tbl[7] = '{a: 8'd255, b: 8'd16,  q: 8'd15,  r: 8'd15};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #23;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_div_by_zero", div_by_zero, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, q, r);
            check($sformatf("tbl%0d_q_const", i), q, tbl[i].q);
            check($sformatf("tbl%0d_r_const", i), r, tbl[i].r);
        end

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (i % 7 == 3) ? '0 : W'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rb, q, r);
        end

        // Back-to-back with start held high; operands swapped while the first is in flight.
        @(negedge clk);
        dividend = 8'd255;
        divisor  = 8'd1;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k <= 26; k++) begin
            if (done) begin
                done_k.push_back(k);
                done_q.push_back(quotient);
                done_r.push_back(remainder);
            end
            if (k == 0) begin
                dividend = 8'd5;
                divisor  = 8'd9;
            end
            if (k == 12) start = 1'b0;
            @(negedge clk);
        end
        check("b2b_done_count", done_k.size(), 2);
        if (done_k.size() == 2) begin
            check("b2b_first_latency", done_k[0], W + 1);
            check("b2b_spacing", done_k[1] - done_k[0], W + 2);
            check("b2b_q0", done_q[0], 255);
            check("b2b_r0", done_r[0], 0);
            check("b2b_q1", done_q[1], 0);
            check("b2b_r1", done_r[1], 5);
        end

        // Starts pulsed during CALC and during DONE must be dropped.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_k.delete();
        for (int k = 0; k <= W + 14; k++) begin
            if (done) done_k.push_back(k);
            start = (k == 3 || k == 8);
            if (start) begin
                dividend = 8'd50;
                divisor  = 8'd3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_done_count", done_k.size(), 1);
        if (done_k.size() > 0) check("ignore_latency", done_k[0], W + 1);
        check("ignore_quotient", quotient, 14);
        check("ignore_remainder", remainder, 2);
        repeat (5) @(negedge clk);
        check("ignore_quotient_hold", quotient, 14);
        check("ignore_busy_after", busy, 0);

        // Asynchronous reset in the 4th CALC cycle, off the clock edges.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_quotient", quotient, 0);
        check("arst_remainder", remainder, 0);
        check("arst_div_by_zero", div_by_zero, 0);
        #1 rst = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("arst_no_done", extra_done, 0);
        check("arst_idle_busy", busy, 0);
        do_op("post_reset", 8'd100, 8'd7, q, r);
        check("post_reset_q_const", q, 14);
        check("post_reset_r_const", r, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
